// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: queues scancode bytes in a small FIFO and
// serialises each as an 11-bit PS/2 frame timed from clk_sys.
module ps2_kbd_tx #(
  parameter int unsigned HALF_PERIOD = 1600,
  parameter int unsigned GAP_CYCLES  = 9600,
  parameter int unsigned FIFO_AW     = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam int unsigned DEPTH   = 1 << FIFO_AW;
  localparam int unsigned LVL_W   = FIFO_AW + 1;
  localparam int unsigned MAX_CNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  // FIFO storage and pointers
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               push_c, pop_c;
  logic [7:0]         head_c;

  assign din_ready = (level != LVL_W'(DEPTH));
  assign push_c    = din_valid & din_ready;
  assign head_c    = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (push_c) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_c, pop_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Frame sequencer state
  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       idx, idx_d;
  logic [9:0]       shreg, shreg_d;
  logic             clk_d, data_d, busy_d;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      shreg    <= shreg_d;
      ps2_clk  <= clk_d;
      ps2_data <= data_d;
      busy     <= busy_d;
    end
  end

  // shreg holds the bits still to go after start: d[7:0], odd parity, stop
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shreg_d = shreg;
    clk_d   = ps2_clk;
    data_d  = ps2_data;
    busy_d  = busy;
    pop_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (level != '0) begin
          pop_c   = 1'b1;
          shreg_d = {1'b1, ~^head_c, head_c};
          idx_d   = '0;
          data_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = HALF_M1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt == '0) begin
          clk_d   = 1'b0;
          cnt_d   = HALF_M1;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_LOW: begin
        if (cnt == '0) begin
          clk_d = 1'b1;
          if (idx < LAST_IDX) begin
            data_d  = shreg[0];
            shreg_d = {1'b0, shreg[9:1]};
            idx_d   = idx + 4'd1;
            cnt_d   = HALF_M1;
            state_d = S_HIGH;
          end else begin
            data_d  = 1'b1;
            cnt_d   = GAP_M1;
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
